count60_ms: RTL
===============

// Module: count60_ms
// PURPOSE
//   Minutes/seconds timebase of the 24-hour clock. Divides clk down to a 1 Hz
//   strobe and keeps BCD seconds (00-59) and minutes (00-59).
//   Emits a one-cycle, glitch-free hour_tick on each 59:59 -> 00:00 rollover.
//   hour_tick drives the clock input of the downstream hour counter.
// PARAMETERS
//   TICK_DIV  50_000_000  clk cycles per second; legal range >= 2
//   PRE_W     $clog2(TICK_DIV)  prescaler width (derived, not overridden)
// PORTS
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous reset, active high
//   en        in   1  run enable; low freezes prescaler and seconds
//   min_inc   in   1  one-cycle pulse: set-mode minute advance
//   clr_sec   in   1  synchronous clear of seconds and prescaler
//   s1        out  4  seconds units, BCD 0-9
//   s10       out  3  seconds tens, 0-5
//   m1        out  4  minutes units, BCD 0-9
//   m10       out  3  minutes tens, 0-5
//   sec_tick  out  1  registered pulse, cycle after each seconds advance
//   hour_tick out  1  registered pulse, cycle after each 59:59 -> 00:00 wrap
// BEHAVIOUR
//   Reset (rst=1, async):
//     - pre=0; s10/s1/m10/m1 = 0; sec_tick=0; hour_tick=0.
//     - Outputs hold these values while rst is high.
//   Prescaler:
//     - If en=1: pre counts 0..TICK_DIV-1, then wraps to 0.
//     - adv = en && pre==TICK_DIV-1 (internal). Exactly one adv per TICK_DIV
//       enabled cycles.
//   Seconds, on the edge where adv=1:
//     - s1 increments. At 9, s1 -> 0 and s10 increments.
//     - At 59, seconds -> 00 and carry_m=1.
//   Minutes:
//     - Advance by 1 when carry_m=1 or min_inc=1. Two simultaneous sources
//       still give +1 only.
//     - 59 -> 00 wrap.
//   hour_tick:
//     - Set on the edge after a carry_m wrap from minute 59.
//     - min_inc-only wraps do NOT raise hour_tick.
//   sec_tick: registered copy of adv, high for exactly one cycle.
//   Priority per edge: rst > clr_sec > (adv, min_inc).
//     - clr_sec=1: seconds=00 and pre=0.
//     - No adv that cycle: no sec_tick, no carry, no hour_tick.
//     - min_inc is still honoured in the same cycle.
//   en=0:
//     - pre and seconds hold; no ticks are generated.
//     - min_inc and clr_sec stay functional.
//   Digits are never outside BCD range. Out-of-range values are unreachable.
//   Latency:
//     - Digits update on the adv edge.
//     - sec_tick/hour_tick are one cycle later (driven from flops, glitch-free).
//   Reset mid-operation: all state returns to 0 immediately. A pending tick
//   pulse is cancelled.
// TESTING  (TICK_DIV=4 in bench)
//   T1 rst=1 for 3 cycles, then 0, en=1, 12 cycles
//      -> 00:00 held during reset;
//      -> s1=1 after 4th enabled edge, s1=3 after 12th;
//      -> sec_tick pulses 3x, one cycle wide.
//   T2 run from 00:00 for 60*4 cycles
//      -> m10m1:s10s1 = 01:00; no hour_tick.
//   T3 run to 59:59, one more adv
//      -> 00:00 on that edge; hour_tick=1 for exactly the next cycle only.
//   T4 at mm=59, ss=30, pulse min_inc
//      -> minutes=00, seconds unchanged, hour_tick stays 0.
//   T5 min_inc coincident with carry at 12:59
//      -> 13:00, not 14:00.
//   T6 clr_sec at pre=3 with ss=59, mm=59
//      -> seconds=00, minutes stay 59, no sec_tick or hour_tick.
//   T7 en=0 for 20 cycles mid-count
//      -> digits and pre frozen, no ticks.
//   T8 rst asserted asynchronously (mid-cycle) during hour_tick
//      -> all outputs 0 at once.

Source files
------------

// File: rtl/count60_ms.sv
// Minutes/seconds timebase: divides clk to a 1 Hz advance, keeps BCD mm:ss and
// emits registered sec_tick / hour_tick pulses for downstream counters.
module count60_ms #(
    parameter  int TICK_DIV = 50_000_000,
    localparam int PRE_W    = $clog2(TICK_DIV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             min_inc_i,
    input  logic             clr_sec_i,
    output logic [3:0]       s1_o,
    output logic [2:0]       s10_o,
    output logic [3:0]       m1_o,
    output logic [2:0]       m10_o,
    output logic             sec_tick_o,
    output logic             hour_tick_o,
    output logic [PRE_W-1:0] pre_o
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [3:0]       s1_q, s1_d;
    logic [2:0]       s10_q, s10_d;
    logic [3:0]       m1_q, m1_d;
    logic [2:0]       m10_q, m10_d;
    logic             sec_tick_q, sec_tick_d;
    logic             hour_tick_q, hour_tick_d;

    logic adv;
    logic sec_adv;
    logic sec_at_59;
    logic min_at_59;
    logic carry_m;
    logic min_step;

    assign adv       = en_i && (pre_q == PRE_LAST);
    // clr_sec outranks the advance: a clear on the wrap cycle swallows it.
    assign sec_adv   = adv && !clr_sec_i;
    assign sec_at_59 = (s10_q == 3'd5) && (s1_q == 4'd9);
    assign min_at_59 = (m10_q == 3'd5) && (m1_q == 4'd9);
    assign carry_m   = sec_adv && sec_at_59;
    assign min_step  = carry_m || min_inc_i;

    always_comb begin
        pre_d = pre_q;
        s1_d  = s1_q;
        s10_d = s10_q;
        if (clr_sec_i) begin
            pre_d = '0;
            s1_d  = 4'd0;
            s10_d = 3'd0;
        end else if (en_i) begin
            pre_d = adv ? '0 : pre_q + PRE_W'(1);
            if (adv) begin
                if (s1_q == 4'd9) begin
                    s1_d  = 4'd0;
                    s10_d = (s10_q == 3'd5) ? 3'd0 : s10_q + 3'd1;
                end else begin
                    s1_d = s1_q + 4'd1;
                end
            end
        end
    end

    // Coincident carry and min_inc collapse into a single +1.
    always_comb begin
        m1_d  = m1_q;
        m10_d = m10_q;
        if (min_step) begin
            if (m1_q == 4'd9) begin
                m1_d  = 4'd0;
                m10_d = (m10_q == 3'd5) ? 3'd0 : m10_q + 3'd1;
            end else begin
                m1_d = m1_q + 4'd1;
            end
        end
    end

    always_comb begin
        sec_tick_d  = sec_adv;
        hour_tick_d = carry_m && min_at_59;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q       <= '0;
            s1_q        <= 4'd0;
            s10_q       <= 3'd0;
            m1_q        <= 4'd0;
            m10_q       <= 3'd0;
            sec_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            s1_q        <= s1_d;
            s10_q       <= s10_d;
            m1_q        <= m1_d;
            m10_q       <= m10_d;
            sec_tick_q  <= sec_tick_d;
            hour_tick_q <= hour_tick_d;
        end
    end

    assign s1_o        = s1_q;
    assign s10_o       = s10_q;
    assign m1_o        = m1_q;
    assign m10_o       = m10_q;
    assign sec_tick_o  = sec_tick_q;
    assign hour_tick_o = hour_tick_q;
    assign pre_o       = pre_q;

endmodule
